// File: rtl/sseg_scan_capture_if.sv
// Seven-segment scan bus as seen by the capture monitor: the observed
// an/sseg pair plus the rebuilt frame, pulses and stale flag.
// Optional macro SSEG_CAP_MISMATCH_EN adds the seg_mismatch signal.
interface sseg_scan_capture_if;
    logic [3:0] an;
    logic [7:0] sseg;
    logic [7:0] digit0;
    logic [7:0] digit1;
    logic [7:0] digit2;
    logic [7:0] digit3;
    logic       frame_valid;
    logic       frame_changed;
    logic       sel_err;
    logic       stale;
`ifdef SSEG_CAP_MISMATCH_EN
    logic       seg_mismatch;

    modport master (
        output an, sseg,
        input  digit0, digit1, digit2, digit3,
        input  frame_valid, frame_changed, sel_err, stale, seg_mismatch
    );

    modport slave (
        input  an, sseg,
        output digit0, digit1, digit2, digit3,
        output frame_valid, frame_changed, sel_err, stale, seg_mismatch
    );
`else
    modport master (
        output an, sseg,
        input  digit0, digit1, digit2, digit3,
        input  frame_valid, frame_changed, sel_err, stale
    );

    modport slave (
        input  an, sseg,
        output digit0, digit1, digit2, digit3,
        output frame_valid, frame_changed, sel_err, stale
    );
`endif
endinterface

// File: rtl/sseg_scan_capture.sv
// Seven-segment scan capture: watches the multiplexed an/sseg bus, samples
// each digit after its select has settled, and publishes complete frames.
// Optional macro SSEG_CAP_MISMATCH_EN adds seg_mismatch (resample with a
// different value inside one frame).
module sseg_scan_capture #(
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned TIMEOUT_CYC = 262_144
) (
    input  logic               clk,
    input  logic               reset_n,
    sseg_scan_capture_if.slave bus
);
    localparam int unsigned    TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT_CYC);
    localparam logic [7:0]     SETTLE_W = 8'(SETTLE);

    typedef enum logic [1:0] {IDLE, SETTLING, SAMPLED} state_t;

    state_t        state, state_nx;
    logic [3:0]    an_q, an_prev;
    logic [7:0]    sseg_q;
    logic [7:0]    cnt, cnt_nx, run;
    logic [7:0]    shadow   [4];
    logic [7:0]    digit_r  [4];
    logic [3:0]    seen;
    logic [TW-1:0] tcnt;
    logic [1:0]    idx;
    logic          legal, illegal, prev_illegal;
    logic          sample, commit;
    logic          fv_r, fc_r, se_r;

    assign legal        = $onehot(~an_q);
    assign illegal      = (an_q != 4'hF) && !legal;
    assign prev_illegal = (an_prev != 4'hF) && !$onehot(~an_prev);
    assign commit       = (seen == 4'hF);

    // Decode the selected digit position from a legal select.
    always_comb begin
        idx = 2'd0;
        case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Input stage: one register on the observed bus, plus the previous select.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            an_q    <= 4'hF;
            an_prev <= 4'hF;
            sseg_q  <= 8'hFF;
        end else begin
            an_q    <= bus.an;
            an_prev <= an_q;
            sseg_q  <= bus.sseg;
        end
    end

    // Dwell FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Dwell FSM next state: count settled cycles, sample once per dwell.
    // run is the length of the current legal dwell including this cycle,
    // so SETTLE=1 samples on the first legal cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        run      = 8'd1;
        sample   = 1'b0;
        if (!legal) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == SAMPLED && an_q == an_prev) begin
            state_nx = SAMPLED;
        end else begin
            run    = (state == SETTLING && an_q == an_prev) ? cnt + 8'd1 : 8'd1;
            cnt_nx = run;
            if (run == SETTLE_W) begin
                sample   = 1'b1;
                state_nx = SAMPLED;
            end else begin
                state_nx = SETTLING;
            end
        end
    end

    // Shadow capture, seen tracking and frame commit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                shadow[i]  <= 8'hFF;
                digit_r[i] <= 8'hFF;
            end
            seen  <= '0;
            fv_r  <= 1'b0;
            fc_r  <= 1'b0;
            se_r  <= 1'b0;
        end else begin
            if (sample)
                shadow[idx] <= sseg_q;
            // A sample landing in the commit cycle starts the next frame.
            seen <= (commit ? 4'h0 : seen) | (sample ? (4'b0001 << idx) : 4'h0);
            fv_r <= commit;
            fc_r <= commit && ({shadow[3], shadow[2], shadow[1], shadow[0]} !=
                               {digit_r[3], digit_r[2], digit_r[1], digit_r[0]});
            if (commit) begin
                for (int unsigned i = 0; i < 4; i++)
                    digit_r[i] <= shadow[i];
            end
            se_r <= illegal && !prev_illegal;
        end
    end

    // Stale timeout: cleared by a commit, otherwise saturating count.
    always_ff @(posedge clk) begin
        if (!reset_n)
            tcnt <= '0;
        else if (commit)
            tcnt <= '0;
        else if (tcnt != TMAX)
            tcnt <= tcnt + 1'b1;
    end

`ifdef SSEG_CAP_MISMATCH_EN
    logic mm_r;

    // Flag a resample of an already-seen digit that carries a different value.
    always_ff @(posedge clk) begin
        if (!reset_n)
            mm_r <= 1'b0;
        else
            mm_r <= sample && (commit ? 1'b0 : seen[idx]) && (shadow[idx] != sseg_q);
    end

    assign bus.seg_mismatch = mm_r;
`endif

    assign bus.digit0        = digit_r[0];
    assign bus.digit1        = digit_r[1];
    assign bus.digit2        = digit_r[2];
    assign bus.digit3        = digit_r[3];
    assign bus.frame_valid   = fv_r;
    assign bus.frame_changed = fc_r;
    assign bus.sel_err       = se_r;
    assign bus.stale         = (tcnt == TMAX);
endmodule

// File: tb/tb_sseg_scan_capture.sv
// Bench for sseg_scan_capture: dwell-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sseg_scan_capture;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    sseg_scan_capture_if bus();

    sseg_scan_capture #(.SETTLE(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // reference model state
    logic [7:0] m_shadow [4];
    logic [7:0] m_digit  [4];
    logic [3:0] m_seen;
    logic       m_fv, m_fc, m_se, m_mm;
    int         m_tcnt;
    int         run;
    logic [3:0] prev_pin;
    logic       pend_v, pend_sel;
    int         pend_idx;
    logic [7:0] pend_data;

    // observation statistics from DUT outputs
    int unsigned cycle = 0;
    int unsigned fv_cnt = 0, sel_cnt = 0, mm_cnt = 0;
    logic        last_fc = 1'b0;
    int unsigned last_fv_cycle = 0, stale_rise_cycle = 0;
    logic        prev_stale = 1'b0, stale_fell_ok = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cycle);
    endtask

    function automatic int zeros(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) n++;
        return n;
    endfunction

    function automatic int zero_pos(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (!a[i]) return i;
        return 0;
    endfunction

    // Dwell model: a digit is captured when its select pin has held the same
    // legal value for exactly SETTLE pin cycles; the effect shows one edge later.
    task automatic model_step();
        logic       c, chg;
        logic [3:0] base;
        int         z;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 8'hFF;
                m_digit[i]  = 8'hFF;
            end
            m_seen = 4'h0; m_fv = 0; m_fc = 0; m_se = 0; m_mm = 0; m_tcnt = 0;
            run = 0; prev_pin = 4'hF; pend_v = 0; pend_sel = 0; pend_idx = 0; pend_data = 8'hFF;
        end else begin
            c    = (m_seen == 4'hF);
            base = c ? 4'h0 : m_seen;
            m_mm = pend_v && base[pend_idx] && (m_shadow[pend_idx] != pend_data);
            chg  = 1'b0;
            for (int i = 0; i < 4; i++) if (m_shadow[i] != m_digit[i]) chg = 1'b1;
            m_fv = c;
            m_fc = c && chg;
            if (c) for (int i = 0; i < 4; i++) m_digit[i] = m_shadow[i];
            if (pend_v) begin
                m_shadow[pend_idx] = pend_data;
                base[pend_idx] = 1'b1;
            end
            m_seen = base;
            m_se = pend_sel;
            if (c) m_tcnt = 0;
            else if (m_tcnt < TMO) m_tcnt++;
            z = zeros(bus.an);
            if (z == 1) run = (bus.an == prev_pin) ? ((run < 1000) ? run + 1 : run) : 1;
            else run = 0;
            pend_v    = (z == 1) && (run == SETTLE);
            pend_idx  = zero_pos(bus.an);
            pend_data = bus.sseg;
            pend_sel  = (z >= 2) && (zeros(prev_pin) < 2);
            prev_pin  = bus.an;
        end
    endtask

    // Compare process: model advances on each edge, DUT sampled 1 time unit later.
    initial begin : monitor
        logic [63:0] got, want;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            cycle++;
            got  = '0;
            want = '0;
            got[35:0]  = {bus.digit3, bus.digit2, bus.digit1, bus.digit0,
                          bus.frame_valid, bus.frame_changed, bus.sel_err, bus.stale};
            want[35:0] = {m_digit[3], m_digit[2], m_digit[1], m_digit[0],
                          m_fv, m_fc, m_se, (m_tcnt == TMO)};
`ifdef SSEG_CAP_MISMATCH_EN
            got[36]  = bus.seg_mismatch;
            want[36] = m_mm;
            if (bus.seg_mismatch === 1'b1) mm_cnt++;
`endif
            check("model_outputs", got, want);
            if (bus.frame_valid === 1'b1) begin
                fv_cnt++;
                last_fc = bus.frame_changed;
                last_fv_cycle = cycle;
                if (prev_stale && bus.stale === 1'b0) stale_fell_ok = 1'b1;
            end
            if (bus.sel_err === 1'b1) sel_cnt++;
            if (bus.stale === 1'b1 && !prev_stale) stale_rise_cycle = cycle;
            prev_stale = (bus.stale === 1'b1);
        end
    end

    task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            bus.an   = a;
            bus.sseg = s;
        end
    endtask

    task automatic rotation(input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3,
                            input int unsigned d2);
        dwell(4'b1110, v0, 8);
        dwell(4'b1101, v1, 8);
        dwell(4'b1011, v2, d2);
        dwell(4'b0111, v3, 8);
    endtask

    task automatic do_reset(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            reset_n  = 1'b0;
            bus.an   = 4'($urandom);
            bus.sseg = 8'($urandom);
        end
        @(negedge clk);
        reset_n  = 1'b1;
        bus.an   = 4'hF;
        bus.sseg = 8'hFF;
    endtask

    initial begin : stim
        int unsigned f0, s0, m0;
        logic [3:0]  a;
        int unsigned x, y;
        bus.an   = 4'hF;
        bus.sseg = 8'hFF;

        // reset with arbitrary inputs
        repeat (3) begin
            @(negedge clk);
            bus.an   = 4'($urandom);
            bus.sseg = 8'($urandom);
        end
        check("reset_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 64'hFFFF_FFFF);
        check("reset_flags", {bus.frame_valid, bus.frame_changed, bus.sel_err, bus.stale}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.an = 4'hF;
        bus.sseg = 8'hFF;

        // normal frame, then identical repeat
        do_reset(2);
        f0 = fv_cnt;
        rotation(8'hFF, 8'hF9, 8'hCF, 8'hFF, 8);
        dwell(4'hF, 8'hFF, 4);
        check("normal_fv_count", 64'(fv_cnt - f0), 64'd1);
        check("normal_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 64'hFFCF_F9FF);
        check("normal_changed", 64'(last_fc), 64'd1);
        f0 = fv_cnt;
        rotation(8'hFF, 8'hF9, 8'hCF, 8'hFF, 8);
        dwell(4'hF, 8'hFF, 4);
        check("repeat_fv_count", 64'(fv_cnt - f0), 64'd1);
        check("repeat_changed", 64'(last_fc), 64'd0);

        // short dwell on digit2, then restored
        do_reset(2);
        f0 = fv_cnt;
        rotation(8'h11, 8'h22, 8'h33, 8'h44, 3);
        dwell(4'hF, 8'hFF, 4);
        check("short_no_frame", 64'(fv_cnt - f0), 64'd0);
        rotation(8'h55, 8'h66, 8'h77, 8'h88, 8);
        dwell(4'hF, 8'hFF, 4);
        check("restored_fv_count", 64'(fv_cnt - f0), 64'd1);
        check("restored_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 64'h4477_6655);

        // illegal select stretch
        do_reset(2);
        s0 = sel_cnt;
        f0 = fv_cnt;
        dwell(4'b1100, 8'h5A, 5);
        dwell(4'b1000, 8'hA5, 2);
        rotation(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8);
        dwell(4'hF, 8'hFF, 4);
        check("illegal_sel_err_count", 64'(sel_cnt - s0), 64'd1);
        check("illegal_then_frame", 64'(fv_cnt - f0), 64'd1);
        check("illegal_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 64'hDDCC_BBAA);

        // stale timeout
        do_reset(2);
        rotation(8'h01, 8'h02, 8'h03, 8'h04, 8);
        dwell(4'hF, 8'hFF, 90);
        check("stale_high", 64'(bus.stale), 64'd1);
        check("stale_rise_delay", 64'(stale_rise_cycle - last_fv_cycle), 64'd64);
        stale_fell_ok = 1'b0;
        rotation(8'h05, 8'h06, 8'h07, 8'h08, 8);
        dwell(4'hF, 8'hFF, 4);
        check("stale_fell_with_fv", 64'(stale_fell_ok), 64'd1);
        check("stale_low", 64'(bus.stale), 64'd0);

`ifdef SSEG_CAP_MISMATCH_EN
        // resample digit1 with a different value inside one frame
        do_reset(2);
        m0 = mm_cnt;
        dwell(4'b1101, 8'hF9, 8);
        dwell(4'hF, 8'hFF, 2);
        dwell(4'b1101, 8'hCF, 8);
        dwell(4'b1110, 8'h00, 8);
        dwell(4'b1011, 8'h00, 8);
        dwell(4'b0111, 8'h00, 8);
        dwell(4'hF, 8'hFF, 4);
        check("mismatch_count", 64'(mm_cnt - m0), 64'd1);
        check("mismatch_digit1", 64'(bus.digit1), 64'hCF);
`endif

        // randomized traffic against the model
        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            x = $urandom_range(0, 11);
            if (x <= 6) begin
                a = ~(4'b0001 << $urandom_range(0, 3));
            end else if (x == 7) begin
                a = 4'hF;
            end else if (x <= 9) begin
                x = $urandom_range(0, 3);
                y = (x + $urandom_range(1, 3)) % 4;
                a = 4'($urandom) & ~(4'b0001 << x) & ~(4'b0001 << y);
            end else if (x == 10 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                reset_n = 1'b0;
                bus.an  = 4'($urandom);
                @(negedge clk);
                reset_n = 1'b1;
                a = 4'hF;
            end else begin
                a = ~(4'b0001 << $urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0: dwell(a, 8'hFF, $urandom_range(1, 10));
                    1: dwell(a, 8'hF9, $urandom_range(1, 10));
                    2: dwell(a, 8'hCF, $urandom_range(1, 10));
                    default: dwell(a, 8'hA4, $urandom_range(1, 10));
                endcase
            end else begin
                dwell(a, 8'($urandom), $urandom_range(1, 10));
            end
        end
        dwell(4'hF, 8'hFF, 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
